// File: rtl/interfaz_alu.sv
`default_nettype none
// ============================================================================
// Module      : interfaz_alu
// Description : Collects operand A, operand B and opcode bytes from a UART
//               receiver, strobes the ALU, then sends the result byte back.
// Revision    : 1.0 - initial release
// ============================================================================
module interfaz_alu #(
    parameter int NB_DATA     = 8,
    parameter int NB_OPERADOR = 6,
    parameter int TIMEOUT     = 1000000
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NB_DATA-1:0]     i_rx_data,
    input  logic                   i_rx_done,
    input  logic [NB_DATA-1:0]     i_alu_result,
    input  logic                   i_tx_done,
    output logic [NB_DATA-1:0]     o_dato_a,
    output logic [NB_DATA-1:0]     o_dato_b,
    output logic [NB_OPERADOR-1:0] o_operador,
    output logic                   o_alu_valid,
    output logic [NB_DATA-1:0]     o_tx_data,
    output logic                   o_tx_start,
    output logic                   o_busy,
    output logic                   o_timeout
);

    localparam int                NB_CNT    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [NB_CNT-1:0] c_cnt_max = NB_CNT'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [NB_CNT-1:0]      r_cnt;
    logic [NB_DATA-1:0]     r_dato_a;
    logic [NB_DATA-1:0]     r_dato_b;
    logic [NB_OPERADOR-1:0] r_operador;
    logic [NB_DATA-1:0]     r_tx_data;
    logic                   r_timeout;
    logic                   w_load_a;
    logic                   w_load_b;
    logic                   w_load_op;
    logic                   w_expire;
    logic                   w_cnt_run;
    logic                   w_cnt_hit;

    assign w_cnt_run = (r_state == WAIT_B) || (r_state == WAIT_OP);
    assign w_cnt_hit = (r_cnt == c_cnt_max);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= WAIT_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A byte arriving on the expiry cycle wins over the timeout.
    always_comb begin
        w_next_state = r_state;
        w_load_a     = 1'b0;
        w_load_b     = 1'b0;
        w_load_op    = 1'b0;
        w_expire     = 1'b0;
        case (r_state)
            WAIT_A: begin
                if (i_rx_done) begin
                    w_load_a     = 1'b1;
                    w_next_state = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    w_load_b     = 1'b1;
                    w_next_state = WAIT_OP;
                end else if (w_cnt_hit) begin
                    w_expire     = 1'b1;
                    w_next_state = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    w_load_op    = 1'b1;
                    w_next_state = EXEC;
                end else if (w_cnt_hit) begin
                    w_expire     = 1'b1;
                    w_next_state = WAIT_A;
                end
            end
            EXEC:    w_next_state = SEND;
            SEND:    w_next_state = WAIT_TX;
            WAIT_TX: begin
                if (i_tx_done) begin
                    w_next_state = WAIT_A;
                end
            end
            default: w_next_state = WAIT_A;
        endcase
    end

    // Counter only runs while waiting for the second or third byte of a frame.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (w_cnt_run && !i_rx_done && !w_cnt_hit) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_dato_a   <= '0;
            r_dato_b   <= '0;
            r_operador <= '0;
            r_tx_data  <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (w_load_a) begin
                r_dato_a <= i_rx_data;
            end
            if (w_load_b) begin
                r_dato_b <= i_rx_data;
            end
            if (w_load_op) begin
                r_operador <= i_rx_data[NB_OPERADOR-1:0];
            end
            if (r_state == EXEC) begin
                r_tx_data <= i_alu_result;
            end
        end
    end

    assign o_dato_a    = r_dato_a;
    assign o_dato_b    = r_dato_b;
    assign o_operador  = r_operador;
    assign o_tx_data   = r_tx_data;
    assign o_timeout   = r_timeout;
    assign o_alu_valid = (r_state == EXEC);
    assign o_tx_start  = (r_state == SEND);
    assign o_busy      = (r_state == EXEC) || (r_state == SEND) || (r_state == WAIT_TX);

endmodule
`default_nettype wire
